// File: rtl/video_binary_filter_pkg.sv
// video_binary_filter_pkg: shared modes, RGB565 layout and helpers for the binary filter.
package video_binary_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_RAW   = 2'b01,
        MODE_MAJ   = 2'b10,
        MODE_ERODE = 2'b11
    } mode_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    function automatic logic binarise(input rgb565_t p, input logic [4:0] tr,
                                      input logic [5:0] tg, input logic [4:0] tb);
        return (p.r > tr) | (p.g > tg) | (p.b > tb);
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) n += {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/video_binary_filter_line_buffer.sv
// video_binary_filter_line_buffer: clock-enabled 1-bit delay line with one tap per DEPTH stage.
module video_binary_filter_line_buffer #(
    parameter int DEPTH = 640,
    parameter int TAPS  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            d,
    output logic [TAPS-1:0] taps
);

    logic [DEPTH*TAPS-1:0] sr;

    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else if (en) sr <= {sr[DEPTH*TAPS-2:0], d};

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        assign taps[g] = sr[DEPTH*(g+1)-1];
    end

endmodule

// File: rtl/video_binary_filter.sv
// video_binary_filter: RGB565 binariser with 3x3 majority/erode filtering and per-frame
// white-pixel statistics; output is the input stream delayed one enabled clock.
module video_binary_filter
    import video_binary_filter_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int CW       = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_enable,
    input  logic          frame_enable,
    input  logic [15:0]   pixel_color,
    input  logic [4:0]    thr_r,
    input  logic [5:0]    thr_g,
    input  logic [4:0]    thr_b,
    input  logic [1:0]    mode,
    output logic          clk_out_enable,
    output logic          frame_out_enable,
    output logic [15:0]   pixel_out_color,
    output logic [XW-1:0] current_pos_x,
    output logic [YW-1:0] current_pos_y,
    output logic          tx_int,
    output logic [CW-1:0] white_count,
    output logic          frame_done
);

    logic       armed, live, in_frame, rise, fall, y_sat, valid, b, pix_white, white;
    mode_t      mode_q, mode_eff;
    logic [1:0] lines;
    logic [2:0] col, w1, w2;
    logic [8:0] win;
    logic [CW-1:0] acc;

    // Taps above row 0 or left of column 0 are masked here, so stale line-buffer
    // contents from the previous frame never leak into the window.
    always_comb begin
        in_frame  = frame_enable & armed;
        rise      = in_frame & ~frame_out_enable;
        fall      = ~frame_enable & frame_out_enable;
        y_sat     = current_pos_y == YW'(V_ACTIVE);
        valid     = clk_enable & in_frame & ~y_sat;
        mode_eff  = rise ? mode_t'(mode) : mode_q;
        b         = binarise(rgb565_t'(pixel_color), thr_r, thr_g, thr_b);
        col       = {lines[1] & (current_pos_y > YW'(1)), lines[0] & (current_pos_y != '0), b};
        win       = {col, w1 & {3{current_pos_x != '0}}, w2 & {3{current_pos_x > XW'(1)}}};
        pix_white = mode_eff == MODE_RAW   ? b :
                    mode_eff == MODE_MAJ   ? popcount9(win) >= 4'd5 :
                    mode_eff == MODE_ERODE ? &win : 1'b0;
        white     = valid & pix_white;
        tx_int    = live & ~y_sat;
    end

    video_binary_filter_line_buffer #(.DEPTH(H_ACTIVE), .TAPS(2)) u_lines (
        .clk  (clk),
        .rst  (rst),
        .en   (valid),
        .d    (b),
        .taps (lines)
    );

    // armed blocks a frame that was already running when reset released.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            frame_out_enable <= 1'b0;
            clk_out_enable   <= 1'b0;
            armed            <= 1'b0;
            live             <= 1'b0;
            frame_done       <= 1'b0;
            mode_q           <= MODE_PASS;
        end else begin
            frame_out_enable <= frame_enable;
            clk_out_enable   <= clk_enable;
            armed            <= armed | ~frame_enable;
            live             <= in_frame;
            frame_done       <= fall;
            if (rise) mode_q <= mode_t'(mode);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            current_pos_x <= '0;
            current_pos_y <= '0;
        end else if (!in_frame) begin
            current_pos_x <= '0;
            current_pos_y <= '0;
        end else if (valid) begin
            current_pos_x <= current_pos_x == XW'(H_ACTIVE-1) ? '0 : current_pos_x + 1'b1;
            if (current_pos_x == XW'(H_ACTIVE-1)) current_pos_y <= current_pos_y + 1'b1;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w1 <= '0;
            w2 <= '0;
        end else if (!in_frame) begin
            w1 <= '0;
            w2 <= '0;
        end else if (valid) begin
            w1 <= col;
            w2 <= w1;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) pixel_out_color <= '0;
        else if (clk_enable) pixel_out_color <= mode_eff == MODE_PASS ? pixel_color : {16{white}};

    // A pixel coinciding with the falling edge is outside the frame, so the
    // accumulator already holds the final count when it is published.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc         <= '0;
            white_count <= '0;
        end else if (fall) begin
            white_count <= acc;
            acc         <= '0;
        end else if (white && acc != '1) begin
            acc <= acc + 1'b1;
        end

endmodule

// File: tb/tb_video_binary_filter.sv
// tb_video_binary_filter: randomized and directed frames checked against an image-level model.
module tb_video_binary_filter;

    localparam int H  = 12;
    localparam int V  = 6;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int CW = 6;

    logic clk = 1'b0, rst = 1'b0, ce = 1'b0, fe = 1'b0;
    logic [15:0] pix = '0;
    logic [4:0] tr = '0, tb = '0;
    logic [5:0] tg = '0;
    logic [1:0] mode = '0;
    logic clk_out_enable, frame_out_enable, tx_int, frame_done;
    logic [15:0] pixel_out_color;
    logic [XW-1:0] current_pos_x;
    logic [YW-1:0] current_pos_y;
    logic [CW-1:0] white_count;

    int checks = 0, errors = 0;
    bit img [V][H];
    int n = 0, wcnt = 0, exp_wc = 0;
    logic [15:0] exp_out = '0;
    logic [1:0] cur_mode = '0;
    logic prev_fe = 1'b0;

    video_binary_filter #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_enable       (ce),
        .frame_enable     (fe),
        .pixel_color      (pix),
        .thr_r            (tr),
        .thr_g            (tg),
        .thr_b            (tb),
        .mode             (mode),
        .clk_out_enable   (clk_out_enable),
        .frame_out_enable (frame_out_enable),
        .pixel_out_color  (pixel_out_color),
        .current_pos_x    (current_pos_x),
        .current_pos_y    (current_pos_y),
        .tx_int           (tx_int),
        .white_count      (white_count),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic bit bin(input logic [15:0] p);
        return p[15:11] > tr || p[10:5] > tg || p[4:0] > tb;
    endfunction

    // Filter centred one row up and one column left of (xx,yy), zero padding outside the image.
    function automatic bit filt(input int xx, input int yy, input logic [1:0] m);
        int cnt = 0;
        if (m == 2'b01) return img[yy][xx];
        for (int r = yy - 2; r <= yy; r++)
            for (int c = xx - 2; c <= xx; c++)
                if (r >= 0 && c >= 0) cnt += int'(img[r][c]);
        return m == 2'b10 ? cnt >= 5 : cnt == 9;
    endfunction

    function automatic logic [15:0] gen(input int kind, input int idx);
        int x = idx % H, y = idx / H;
        if (idx >= H * V || kind == 0) return 16'($urandom);
        return kind == 1 ? 16'(idx * 37 + 1) :
               kind == 2 ? ((idx % 2) != 0 ? 16'h7800 : 16'h7000) :
               kind == 3 ? (x == 5 && y == 3 ? 16'hFFFF : 16'h0000) :
               kind == 4 ? (x >= 4 && x <= 6 && y >= 2 && y <= 4 ? 16'hFFFF : 16'h0000) :
               16'hFFFF;
    endfunction

    task automatic step(input logic c, input logic f, input logic [15:0] p, input logic [1:0] m);
        bit vpix, wh, fall_m;
        int px, py;
        if (f && !prev_fe) begin
            cur_mode = m;
            n = 0;
        end
        vpix = c && f && n < H * V;
        wh = 1'b0;
        if (vpix) begin
            img[n / H][n % H] = bin(p);
            if (cur_mode != 2'b00) wh = filt(n % H, n / H, cur_mode);
            n++;
        end
        if (c) exp_out = cur_mode == 2'b00 ? p : {16{wh}};
        if (wh) wcnt++;
        fall_m = !f && prev_fe;
        if (fall_m) begin
            exp_wc = wcnt > 63 ? 63 : wcnt;
            wcnt = 0;
        end
        if (!f) n = 0;
        px = f && n < H * V ? n % H : 0;
        py = !f ? 0 : n < H * V ? n / H : V;
        ce = c; fe = f; pix = p; mode = m;
        prev_fe = f;
        @(posedge clk); #1;
        chk("pixel_out_color", 32'(pixel_out_color), 32'(exp_out));
        chk("clk_out_enable", 32'(clk_out_enable), 32'(c));
        chk("frame_out_enable", 32'(frame_out_enable), 32'(f));
        chk("position", 32'({current_pos_y, current_pos_x}), 32'({YW'(py), XW'(px)}));
        chk("tx_int", 32'(tx_int), 32'(f && n < H * V));
        chk("frame_done", 32'(frame_done), 32'(fall_m));
        chk("white_count", 32'(white_count), 32'(exp_wc));
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; fe = 1'b0;
        #1;
        chk("rst_outputs", 32'({pixel_out_color, clk_out_enable, frame_out_enable, tx_int, frame_done}), 32'd0);
        chk("rst_position", 32'({current_pos_y, current_pos_x}), 32'd0);
        chk("rst_white_count", 32'(white_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        prev_fe = 1'b0; cur_mode = 2'b00; n = 0; wcnt = 0; exp_wc = 0; exp_out = '0;
    endtask

    task automatic frame(input int kind, input logic [1:0] m, input logic [1:0] m_alt,
                         input int extra, input int pct);
        int idx;
        logic c;
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b0, 16'($urandom), m);
        step(1'b1, 1'b1, gen(kind, 0), m);
        idx = 1;
        for (int i = 0; i < 4000 && idx < H * V + extra; i++) begin
            c = $urandom_range(99) < pct;
            step(c, 1'b1, c ? gen(kind, idx) : 16'($urandom), m_alt);
            if (c) idx++;
        end
        step(1'($urandom_range(1)), 1'b0, 16'($urandom), m_alt);
        step(1'b0, 1'b0, 16'($urandom), m_alt);
    endtask

    initial begin
        #2;
        do_reset();
        frame(1, 2'b00, 2'b00, 3, 80);
        tr = 5'd14; tg = 6'd28; tb = 5'd14;
        frame(2, 2'b01, 2'b01, 0, 100);
        frame(3, 2'b10, 2'b10, 0, 90);
        chk("single_pixel_majority", 32'(white_count), 32'd0);
        frame(4, 2'b10, 2'b10, 0, 90);
        chk("block_majority", 32'(white_count), 32'd5);
        frame(5, 2'b11, 2'b11, 2, 90);
        chk("erode_full_white", 32'(white_count), 32'((H - 2) * (V - 2)));
        frame(5, 2'b01, 2'b01, 0, 100);
        chk("count_saturates", 32'(white_count), 32'd63);
        frame(1, 2'b00, 2'b10, 0, 85);
        frame(4, 2'b10, 2'b00, 0, 85);
        for (int i = 0; i < 8; i++) begin
            tr = 5'($urandom); tg = 6'($urandom); tb = 5'($urandom);
            frame(0, 2'($urandom), 2'($urandom), $urandom_range(4), $urandom_range(50, 100));
        end
        step(1'b0, 1'b0, 16'h0, 2'b10);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'($urandom), 2'b10);
        do_reset();
        frame(0, 2'b10, 2'b11, 2, 90);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
